core_task_receiver: RTL
=======================

// Module: core_task_receiver
// PURPOSE
//  Core-side end of the scheduler->core task link; one instance per shader core.
//  Captures the core's r0 init value, accepts a task header plus IFNUM body messages
//  (two 16-bit instructions each), and buffers the instructions in a FIFO feeding the
//  core pipeline. Drives core_ready low while a task is in flight; it returns high once
//  the core reports completion.
// PARAMETERS
//  CORE_ID      0   index of this core; selects the exec-mask bit in the header
//  INSTR_SIZE   16  instruction width
//  BUS_TO_CORE  32  message width (= 2*INSTR_SIZE)
//  R0_WIDTH     16  r0 init value width
//  FIFO_DEPTH   8   instruction FIFO entries; power of two, >=2
// PORTS
//  clk              in   1            clock
//  reset            in   1            asynchronous, active-low reset
//  sched_msg_valid  in   1            scheduler presents a message for this core
//  sched_msg        in   BUS_TO_CORE  header or body message
//  sched_init_r0    in   1            this core's init_r0_vect bit
//  sched_r0_data    in   R0_WIDTH     r0 init value
//  core_reading     out  1            message accepted this cycle
//  core_ready       out  1            core idle, can take a new task
//  instr_valid      out  1            FIFO head valid
//  instr            out  INSTR_SIZE   FIFO head instruction
//  instr_last       out  1            head is the task's final instruction
//  instr_ready      in   1            pipeline pops the head
//  core_done        in   1            pipeline retired the task (1-cycle pulse)
//  r0_value         out  R0_WIDTH     captured r0
//  r0_valid         out  1            r0_value loaded for the current/next task
//  proto_err        out  1            sticky protocol-violation flag
// BEHAVIOUR
//  Reset (async, reset==0):
//   - state=IDLE; FIFO empty; r0_value=0; r0_valid=0; proto_err=0; core_ready=1.
//   - core_reading, instr_valid and instr_last are forced 0 while reset is low.
//  Handshake: core_reading is combinational = sched_msg_valid & accept_ok.
//   - A transfer occurs in any cycle where core_reading=1.
//   - Nothing is accepted unless sched_msg_valid=1.
//  Header fields: msg[5:0]=IFNUM; msg[31:16]=exec mask. Task is for this core iff mask[CORE_ID]=1.
//  IDLE (core_ready=1, accept_ok=1):
//   - sched_init_r0=1: r0_value<=sched_r0_data, r0_valid<=1. Allowed in the same cycle as a header.
//   - Header with IFNUM!=0 and mask bit set: rem<=IFNUM, go to RECV; core_ready=0 from the next cycle.
//   - Header with IFNUM==0 or mask bit clear: consumed and dropped; stay IDLE.
//  RECV (accept_ok = FIFO free slots >= 2):
//   - Body push order: msg[15:0] first, then msg[31:16]. Each entry stores INSTR_SIZE+1 bits (last tag).
//   - rem decrements per accepted body message.
//   - When rem==1 is accepted: the upper half is tagged last; go to WAIT_DONE.
//  WAIT_DONE (accept_ok=0):
//   - core_done=1 with FIFO empty: go to IDLE; r0_valid<=0; core_ready=1 next cycle.
//  FIFO:
//   - Push-to-instr_valid latency is 1 cycle.
//   - Pop on instr_valid & instr_ready.
//   - Push(2) and pop(1) in the same cycle is legal: net +1.
//   - Read/write pointers wrap modulo FIFO_DEPTH.
//   - Count width is clog2(FIFO_DEPTH+1). The count never exceeds FIFO_DEPTH by construction.
//  Errors (set proto_err, sticky until reset; the event is otherwise ignored):
//   - sched_init_r0 outside IDLE.
//   - core_done outside WAIT_DONE, or with FIFO non-empty.
//   - Task header accepted while r0_valid=0. The task still runs.
//  Reset mid-task: all state discarded at once; no partial instruction survives.
// TESTING
//  1 Release reset, no stimulus -> core_ready=1, core_reading=0, instr_valid=0, proto_err=0.
//  2 Task flow (CORE_ID=0, instr_ready=1):
//    - Stimulus: init_r0 with r0=16'hBEEF; header 32'h0001_0002; bodies 32'h2222_1111, 32'h4444_3333.
//    - Expect instr 1111, 2222, 3333, 4444 on consecutive pops; instr_last only on 4444.
//    - Expect r0_value=BEEF; core_ready=0 until the cycle after core_done.
//  3 Backpressure (FIFO_DEPTH=8, instr_ready=0, IFNUM=6):
//    - Expect exactly 4 bodies accepted; core_reading stays 0 on the 5th.
//    - Two pops -> 5th accepted next cycle.
//  4 Dropped headers: header 32'h0001_0000 (IFNUM=0) or 32'h0002_0003 (bit0 clear)
//    -> one core_reading pulse; state IDLE; core_ready stays 1; FIFO empty.
//  5 Reset asserted in RECV after 1 of 3 bodies -> same cycle: instr_valid=0, core_ready=1.
//    After release, a fresh 1-body task completes correctly.
//  6 Errors:
//    - core_done while FIFO holds 2 entries -> proto_err=1; task continues; completes on a later core_done.
//    - sched_init_r0 during RECV -> r0_value unchanged.

Source files
------------

// File: rtl/core_task_receiver_if.sv
// ---------------------------------------------------------------------------
// core_task_receiver_if
//   Scheduler -> core task link. The scheduler side (master) presents messages
//   and the r0 init value. The core side (slave) reports acceptance and
//   idleness.
//
//   sched_msg_valid  master->slave  a message is presented this cycle
//   sched_msg        master->slave  header or body message
//   sched_init_r0    master->slave  load sched_r0_data into the core's r0
//   sched_r0_data    master->slave  r0 init value
//   core_reading     slave->master  message accepted this cycle
//   core_ready       slave->master  core idle, can take a new task
// ---------------------------------------------------------------------------
interface core_task_receiver_if #(
    parameter int BUS_TO_CORE = 32,
    parameter int R0_WIDTH    = 16
);
    logic                   sched_msg_valid;
    logic [BUS_TO_CORE-1:0] sched_msg;
    logic                   sched_init_r0;
    logic [R0_WIDTH-1:0]    sched_r0_data;
    logic                   core_reading;
    logic                   core_ready;

    modport master (
        output sched_msg_valid,
        output sched_msg,
        output sched_init_r0,
        output sched_r0_data,
        input  core_reading,
        input  core_ready
    );

    modport slave (
        input  sched_msg_valid,
        input  sched_msg,
        input  sched_init_r0,
        input  sched_r0_data,
        output core_reading,
        output core_ready
    );
endinterface

// File: rtl/core_task_receiver.sv
// ---------------------------------------------------------------------------
// core_task_receiver
//   Core-side end of the scheduler->core task link (one per shader core).
//   It captures the r0 init value and accepts a task header followed by IFNUM
//   body messages. Each body message carries two instructions. The receiver
//   buffers the instructions in a FIFO that feeds the core pipeline.
//   core_ready is low from the cycle after a task header is accepted until the
//   cycle after the core reports completion.
//
// Ports
//   clk          in   clock
//   reset        in   asynchronous, active-low reset
//   sched        if   scheduler link (slave side)
//   instr_valid  out  FIFO head valid
//   instr        out  FIFO head instruction
//   instr_last   out  head is the task's final instruction
//   instr_ready  in   pipeline pops the head
//   core_done    in   pipeline retired the task (1-cycle pulse)
//   r0_value     out  captured r0
//   r0_valid     out  r0_value loaded for the current/next task
//   proto_err    out  sticky protocol-violation flag
//   state_dbg    out  current FSM state (0 IDLE, 1 RECV, 2 WAIT_DONE)
//
// Handshakes: a transfer happens on a rising clk edge when valid and ready are
// both 1. On the scheduler link, valid is sched_msg_valid and ready is
// core_reading. core_reading is combinational and already includes valid.
// On the instruction side, valid is instr_valid and ready is instr_ready.
// The valid signal never depends on its matching ready.
// ---------------------------------------------------------------------------
module core_task_receiver #(
    parameter int CORE_ID     = 0,
    parameter int INSTR_SIZE  = 16,
    parameter int BUS_TO_CORE = 32,
    parameter int R0_WIDTH    = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    core_task_receiver_if.slave   sched,
    output logic                  instr_valid,
    output logic [INSTR_SIZE-1:0] instr,
    output logic                  instr_last,
    input  logic                  instr_ready,
    input  logic                  core_done,
    output logic [R0_WIDTH-1:0]   r0_value,
    output logic                  r0_valid,
    output logic                  proto_err,
    output logic [1:0]            state_dbg
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = INSTR_SIZE + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [5:0]       rem_q;
    logic [5:0]       rem_d;

    // Each FIFO entry is {last_tag, instruction}.
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;

    logic [R0_WIDTH-1:0] r0_value_q;
    logic                r0_valid_q;
    logic                proto_err_q;

    logic       accept_ok;
    logic       fifo_empty;
    logic       fifo_room2;
    logic [5:0] hdr_ifnum;
    logic       hdr_for_me;
    logic       hdr_take;
    logic       body_take;
    logic       body_last;
    logic       pop;
    logic       done_ok;
    logic       r0_load;
    logic       err_evt;

    // ------------------------------------------------------------------
    // Decode and handshake
    // ------------------------------------------------------------------
    assign hdr_ifnum  = sched.sched_msg[5:0];
    assign hdr_for_me = sched.sched_msg[INSTR_SIZE + CORE_ID];

    assign fifo_empty = (count_q == '0);
    // A body message pushes two entries at once, so it needs two free slots.
    assign fifo_room2 = (count_q <= CNT_W'(FIFO_DEPTH - 2));

    always_comb begin
        accept_ok = 1'b0;
        unique case (state_q)
            S_IDLE:  accept_ok = 1'b1;
            S_RECV:  accept_ok = fifo_room2;
            default: accept_ok = 1'b0;
        endcase
    end

    // Gated by reset so that nothing is reported as accepted while reset is held.
    assign sched.core_reading = reset & sched.sched_msg_valid & accept_ok;
    assign sched.core_ready   = (state_q == S_IDLE);
    assign state_dbg          = state_q;

    assign hdr_take  = sched.core_reading && (state_q == S_IDLE)
                       && hdr_for_me && (hdr_ifnum != 6'd0);
    assign body_take = sched.core_reading && (state_q == S_RECV);
    assign body_last = body_take && (rem_q == 6'd1);
    assign pop       = instr_valid & instr_ready;
    assign done_ok   = core_done && (state_q == S_WAIT) && fifo_empty;
    assign r0_load   = sched.sched_init_r0 && (state_q == S_IDLE);

    // A header that arrives together with init_r0 counts as having a valid r0.
    assign err_evt = (sched.sched_init_r0 && (state_q != S_IDLE))
                   | (core_done && !done_ok)
                   | (hdr_take && !r0_valid_q && !r0_load);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (hdr_take) begin
                    rem_d   = hdr_ifnum;
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (body_take) begin
                    rem_d = rem_q - 6'd1;
                    if (body_last) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (done_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rem_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // ------------------------------------------------------------------
    // Instruction FIFO
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        unique case ({body_take, pop})
            2'b10:   count_d = count_q + CNT_W'(2);
            2'b11:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (body_take) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(2);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset. The count is cleared on reset, so stale entries
    // are never presented.
    always_ff @(posedge clk) begin
        if (body_take) begin
            mem[wr_ptr_q]              <= {1'b0, sched.sched_msg[INSTR_SIZE-1:0]};
            mem[wr_ptr_q + PTR_W'(1)]  <= {body_last, sched.sched_msg[2*INSTR_SIZE-1:INSTR_SIZE]};
        end
    end

    assign instr_valid = reset & ~fifo_empty;
    assign instr       = mem[rd_ptr_q][INSTR_SIZE-1:0];
    assign instr_last  = instr_valid & mem[rd_ptr_q][INSTR_SIZE];

    // ------------------------------------------------------------------
    // r0 capture and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r0_value_q  <= '0;
            r0_valid_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (r0_load) begin
                r0_value_q <= sched.sched_r0_data;
                r0_valid_q <= 1'b1;
            end else if (done_ok) begin
                r0_valid_q <= 1'b0;
            end
            if (err_evt) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign r0_value  = r0_value_q;
    assign r0_valid  = r0_valid_q;
    assign proto_err = proto_err_q;

endmodule
